multicycle_controller: RTL and testbench

Control unit for the multicycle RISC-V RV32I-subset core. It decodes `op`/`funct3`/`funct7b5`, and a Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives every datapath select and write enable, including `immsrc` for the immediate extender, using the ALU `zero` flag to resolve branches.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 137 +++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: opcodes, FSM states,
// ALU operation classes and the select codes driven by the controller.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to the ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // NOTE: assign every combinational output a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 means sub only for R-type; for addi it is an immediate bit
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I-subset core, with immediate-format
// decode and branch-resolved PC write.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   branch, pcupdate;
  logic   irwrite_s, regwrite_s, memwrite_s;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_WD;
    resultsrc  = RES_ALUOUT;
    adrsrc     = 1'b0;
    aluop      = ALUOP_ADD;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    branch     = 1'b0;
    pcupdate   = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        pcupdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // precompute the branch target into ALUOut while the opcode is decoded
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: regwrite_s = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: immsrc = IMM_I;
      OP_SW:       immsrc = IMM_S;
      OP_BEQ:      immsrc = IMM_B;
      OP_JAL:      immsrc = IMM_J;
      default:     immsrc = IMM_I;
    endcase
  end

  // enables are gated by reset so nothing is written while it is held low
  assign irwrite  = reset & irwrite_s;
  assign regwrite = reset & regwrite_s;
  assign memwrite = reset & memwrite_s;
  assign pcwrite  = reset & (pcupdate | (branch & zero));

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, cycle-by-cycle bench for multicycle_controller with hand-computed
// expectations for each state of each instruction class.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite;

  int pass_count = 0;
  int check_count = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {irwrite, pcwrite, regwrite, memwrite}
  function automatic logic [7:0] wens();
    return {4'b0, irwrite, pcwrite, regwrite, memwrite};
  endfunction

  initial begin
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;

    // reset held low
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_wen", wens(), 8'b0000);
      check("rst_srcb", {6'b0, alusrcb}, 8'h2);
    end
    reset = 1'b1;
    #1;
    check("rel_fetch_wen", wens(), 8'b1100);

    // R-type sub
    tick();
    check("r_dec_srca", {6'b0, alusrca}, 8'h1);
    check("r_dec_wen", wens(), 8'b0000);
    tick();
    check("r_exe_aluctl", {5'b0, alucontrol}, 8'h1);
    check("r_exe_srcb", {6'b0, alusrcb}, 8'h0);
    tick();
    check("r_wb_wen", wens(), 8'b0010);
    tick();
    check("r_fetch_wen", wens(), 8'b1100);

    // lw: 5 cycles
    op = 7'b0000011;
    #1;
    check("lw_imm", {6'b0, immsrc}, 8'h0);
    tick();
    check("lw_dec_wen", wens(), 8'b0000);
    tick();
    check("lw_adr_srca", {6'b0, alusrca}, 8'h2);
    check("lw_adr_wen", wens(), 8'b0000);
    tick();
    check("lw_rd_adrsrc", {7'b0, adrsrc}, 8'h1);
    check("lw_rd_wen", wens(), 8'b0000);
    tick();
    check("lw_wb_wen", wens(), 8'b0010);
    check("lw_wb_res", {6'b0, resultsrc}, 8'h1);
    tick();
    check("lw_fetch_wen", wens(), 8'b1100);

    // beq taken then not taken
    for (int t = 0; t < 2; t++) begin
      op = 7'b1100011;
      zero = 1'b1;
      tick();
      check("beq_dec_wen", wens(), 8'b0000);
      tick();
      zero = (t == 0);
      #1;
      check("beq_imm", {6'b0, immsrc}, 8'h2);
      check("beq_aluctl", {5'b0, alucontrol}, 8'h1);
      check("beq_pcwrite", {7'b0, pcwrite}, {7'b0, t == 0});
      tick();
      check("beq_fetch_wen", wens(), 8'b1100);
    end
    zero = 1'b0;

    // I-type addi with funct7b5 set, then funct3 sweep
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    check("i_aluctl_add", {5'b0, alucontrol}, 8'h0);
    check("i_srcb", {6'b0, alusrcb}, 8'h1);
    check("i_imm", {6'b0, immsrc}, 8'h0);
    funct3 = 3'b010; #1;
    check("i_aluctl_slt", {5'b0, alucontrol}, 8'h5);
    funct3 = 3'b110; #1;
    check("i_aluctl_or", {5'b0, alucontrol}, 8'h3);
    funct3 = 3'b111; #1;
    check("i_aluctl_and", {5'b0, alucontrol}, 8'h2);
    funct3 = 3'b001; #1;
    check("i_aluctl_other", {5'b0, alucontrol}, 8'h0);
    tick();
    check("i_wb_wen", wens(), 8'b0010);
    tick();
    check("i_fetch_wen", wens(), 8'b1100);

    // jal: 4 cycles
    op = 7'b1101111;
    #1;
    check("jal_imm", {6'b0, immsrc}, 8'h3);
    tick();
    tick();
    check("jal_wen", wens(), 8'b0100);
    check("jal_srca", {6'b0, alusrca}, 8'h1);
    check("jal_srcb", {6'b0, alusrcb}, 8'h2);
    tick();
    check("jal_wb_wen", wens(), 8'b0010);
    tick();
    check("jal_fetch_wen", wens(), 8'b1100);

    // illegal opcode: 2 cycles
    op = 7'b1111111;
    zero = 1'b1;
    tick();
    check("ill_dec_wen", wens(), 8'b0000);
    tick();
    check("ill_fetch_wen", wens(), 8'b1100);
    zero = 1'b0;

    // sw completes normally
    op = 7'b0100011;
    #1;
    check("sw_imm", {6'b0, immsrc}, 8'h1);
    tick();
    tick();
    check("sw_adr_wen", wens(), 8'b0000);
    tick();
    check("sw_wr_wen", wens(), 8'b0001);
    check("sw_wr_adrsrc", {7'b0, adrsrc}, 8'h1);
    tick();
    check("sw_fetch_wen", wens(), 8'b1100);

    // sw interrupted by reset in MEMADR
    tick();
    tick();
    check("swr_adr_srca", {6'b0, alusrca}, 8'h2);
    reset = 1'b0;
    #1;
    check("swr_rst_wen", wens(), 8'b0000);
    check("swr_rst_srcb", {6'b0, alusrcb}, 8'h2);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("swr_hold_wen", wens(), 8'b0000);
    end
    reset = 1'b1;
    #1;
    check("swr_rel_wen", wens(), 8'b1100);
    tick();
    check("swr_dec_srca", {6'b0, alusrca}, 8'h1);
    check("swr_dec_wen", wens(), 8'b0000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
